fir_engine_dec: RTL and testbench
=================================

// Module: fir_engine_dec
// PURPOSE
//  Parametrised successor to the fixed 11-tap FIR. It has a configurable tap count and data width, and an optional
//  integer decimation factor. The tap and delay-line storage is held in internal registers, so no external BRAM is used.
//  Taps, data length and decimation are programmed over AXI-Lite. Samples stream in on AXI-Stream slave (ss_*) and
//  results stream out on AXI-Stream master (sm_*). One MAC is performed per cycle.
// PARAMETERS
//  pADDR_WIDTH  12   AXI-Lite address width
//  pDATA_WIDTH  32   sample, tap and accumulator width (two's complement)
//  pTAPS        11   number of taps, 2..32
//  pMAX_DECIM   8    largest legal decimation factor
// PORTS
//  axis_clk   in   1             the single clock
//  axis_rst   in   1             asynchronous reset, active-high
//  awvalid/awready  in/out  1    AXI-Lite write address handshake; awaddr in pADDR_WIDTH
//  wvalid/wready    in/out  1    AXI-Lite write data handshake; wdata in pDATA_WIDTH
//  arvalid/arready  in/out  1    AXI-Lite read address handshake; araddr in pADDR_WIDTH
//  rvalid/rready    out/in  1    AXI-Lite read data handshake; rdata out pDATA_WIDTH
//  ss_tvalid/ss_tready/ss_tlast  in/out/in  1   input stream handshake and last flag; ss_tdata in pDATA_WIDTH
//  sm_tvalid/sm_tready/sm_tlast  out/in/out 1   output stream handshake and last flag; sm_tdata out pDATA_WIDTH
// BEHAVIOUR
//  Reset: all outputs are 0 except ap_idle=1. Registers reset to len=0, decim=1. Taps and delay line reset to 0.
//  Register map:
//   0x00 ap_ctrl: bit0 ap_start (W1, self-clearing), bit1 ap_done (RO, sticky), bit2 ap_idle (RO).
//   0x10 data_length. 0x14 decim; a write of 0 or >pMAX_DECIM stores 1.
//   0x20+4k tap[k] for k<pTAPS. Any other address reads 0; writes to it are dropped.
//  AXI-Lite write:
//   awready=wready=1 for one cycle once awvalid&&wvalid are both high. Register updates on that edge.
//   Tap, length and decim writes are ignored while ap_idle=0. A write of ap_start while busy is ignored.
//  AXI-Lite read:
//   arready=1 for one cycle on arvalid. rvalid rises on the next cycle and holds, with stable rdata, until rready.
//   Reading 0x00 while ap_done=1 clears ap_done after the rvalid&&rready beat.
//  FSM: IDLE -> (ap_start) CLR -> WAIT_IN -> MAC -> [OUT] -> WAIT_IN | DONE -> IDLE.
//   CLR: zero the delay line and counters; 1 cycle; ap_idle drops to 0 here.
//   WAIT_IN: ss_tready=1, and only in this state. On ss_tvalid, shift ss_tdata into x[0] and increment n.
//   MAC: pTAPS cycles, acc += tap[k]*x[k]. Products and acc are truncated to pDATA_WIDTH (wrap, no saturation).
//   Emit test: a result is emitted only if (n-1) mod decim == 0. Otherwise go straight to WAIT_IN or DONE.
//   OUT: sm_tvalid=1 with sm_tdata and sm_tlast held stable until sm_tready. No output is ever dropped.
//  Latency: a sample accepted at edge t gives sm_tvalid at t+pTAPS+1 when sm_tready is held high.
//   Throughput is one sample per pTAPS+2 cycles.
//  sm_tlast=1 on the last emitted output: the sample index i (0-based) with i+decim >= data_length.
//  ss_tlast is informational only. data_length alone ends the run. A missing or early ss_tlast is not an error.
//  DONE: entered once data_length samples have been accepted and the last result has been sent.
//   Sets ap_done=1 and ap_idle=1 in the same cycle.
//  data_length=0: ap_start goes CLR -> DONE directly. No stream traffic occurs.
//  axis_rst mid-run: FSM goes to IDLE at once and sm_tvalid drops asynchronously. Taps are lost (reset to 0).
//  Simultaneous AXI-Lite read and write to the same address: the read returns the old value.
// TESTING
//  1. Program len=600, decim=1, taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, then ap_start with the triangular-wave
//     stimulus -> 600 outputs match out_gold.dat; sm_tlast is set only on output 599; ap_done=1 and ap_idle=1.
//  2. Same taps, decim=3, len=10, input x=1,2,...,10 -> 4 outputs for i=0,3,6,9, each equal to the golden FIR
//     value at that index; sm_tlast is set on i=9.
//  3. Tap write 0x28=77 during a run -> read-back of 0x28 returns the original -9; the run output is unchanged.
//  4. Hold sm_tready=0 for 50 cycles mid-run -> sm_tdata stays stable, ss_tready=0, and no outputs are lost.
//  5. len=0 then ap_start -> ap_done=1 within 3 cycles; sm_tvalid never rises.
//  6. Assert axis_rst mid-MAC -> the next cycle shows ap_idle=1, sm_tvalid=0 and all taps read 0.

Source files
------------

// File: rtl/fir_engine_dec_if.sv
// rtl/fir_engine_dec_if.sv - register bus and sample stream bundle for fir_engine_dec
interface fir_engine_dec_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) ();
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid, sm_tready, sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_engine_dec.sv
// rtl/fir_engine_dec.sv - register-programmed FIR, one MAC per cycle, optional decimation
module fir_engine_dec #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAPS       = 11,
  parameter int pMAX_DECIM  = 8
) (
  input logic             axis_clk,
  input logic             axis_rst,
  fir_engine_dec_if.slave bus
);
  localparam int AW = pADDR_WIDTH;
  localparam int DW = pDATA_WIDTH;
  localparam int KW = $clog2(pTAPS);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_WAIT, S_MAC, S_OUT, S_DONE} state_t;

  state_t        state, nxt;
  logic [DW-1:0] taps [pTAPS];
  logic [DW-1:0] x    [pTAPS];
  logic [DW-1:0] len_r, decim_r, n_r, ph_r, acc_r, prod;
  logic [KW-1:0] k_r;
  logic          emit_r, last_r, done_r, aw_ack, ar_ack, rd_ctrl;
  logic          ap_idle, ap_done, wr_fire, rd_fire, start_fire;
  logic [AW-1:0] wa_off, ra_off;
  logic          wa_tap, ra_tap;
  logic [KW-1:0] wa_idx, ra_idx;
  logic [DW-1:0] rd_val;

  assign ap_idle    = (state == S_IDLE) || (state == S_DONE);
  assign ap_done    = done_r || (state == S_DONE);
  assign wr_fire    = bus.awvalid && bus.wvalid && aw_ack;
  assign rd_fire    = bus.arvalid && ar_ack;
  assign start_fire = wr_fire && (bus.awaddr == '0) && bus.wdata[0] && (state == S_IDLE);
  assign prod       = taps[k_r] * x[k_r];

  assign bus.awready   = aw_ack;
  assign bus.wready    = aw_ack;
  assign bus.arready   = ar_ack;
  assign bus.ss_tready = (state == S_WAIT);
  assign bus.sm_tvalid = (state == S_OUT);
  assign bus.sm_tdata  = (state == S_OUT) ? acc_r : '0;
  assign bus.sm_tlast  = (state == S_OUT) && last_r;

  // Tap window decode: 0x20 + 4k, word aligned, k < pTAPS
  always_comb begin
    wa_off = bus.awaddr - AW'(32);
    ra_off = bus.araddr - AW'(32);
    wa_tap = (bus.awaddr >= AW'(32)) && (wa_off[AW-1:2] < (AW-2)'(pTAPS)) && (wa_off[1:0] == 2'b00);
    ra_tap = (bus.araddr >= AW'(32)) && (ra_off[AW-1:2] < (AW-2)'(pTAPS)) && (ra_off[1:0] == 2'b00);
    wa_idx = wa_off[KW+1:2];
    ra_idx = ra_off[KW+1:2];
    rd_val = '0;
    if (bus.araddr == AW'(0))
      rd_val = {{(DW-3){1'b0}}, ap_idle, ap_done, 1'b0};
    else if (bus.araddr == AW'(16))
      rd_val = len_r;
    else if (bus.araddr == AW'(20))
      rd_val = decim_r;
    else if (ra_tap)
      rd_val = taps[ra_idx];
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start_fire) nxt = S_CLR;
      S_CLR:  nxt = (len_r == '0) ? S_DONE : S_WAIT;
      S_WAIT: if (bus.ss_tvalid) nxt = S_MAC;
      S_MAC:
        if (k_r == KW'(pTAPS - 1))
          nxt = emit_r ? S_OUT : ((n_r == len_r) ? S_DONE : S_WAIT);
      S_OUT:
        if (bus.sm_tready) nxt = (n_r == len_r) ? S_DONE : S_WAIT;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int j = 0; j < pTAPS; j++) begin
        taps[j] <= '0;
        x[j]    <= '0;
      end
      len_r     <= '0;
      decim_r   <= DW'(1);
      n_r       <= '0;
      ph_r      <= '0;
      acc_r     <= '0;
      k_r       <= '0;
      emit_r    <= 1'b0;
      last_r    <= 1'b0;
      done_r    <= 1'b0;
      aw_ack    <= 1'b0;
      ar_ack    <= 1'b0;
      rd_ctrl   <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      aw_ack <= bus.awvalid && bus.wvalid && !aw_ack;
      ar_ack <= bus.arvalid && !ar_ack && !bus.rvalid;

      // rdata is captured before this edge's write lands, so a same-address read sees the old value
      if (rd_fire) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_val;
        rd_ctrl    <= (bus.araddr == AW'(0));
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end

      if (state == S_DONE)
        done_r <= 1'b1;
      else if (bus.rvalid && bus.rready && rd_ctrl && bus.rdata[1])
        done_r <= 1'b0;

      if (wr_fire && ap_idle) begin
        if (bus.awaddr == AW'(16))
          len_r <= bus.wdata;
        else if (bus.awaddr == AW'(20))
          decim_r <= ((bus.wdata == '0) || (bus.wdata > DW'(pMAX_DECIM))) ? DW'(1) : bus.wdata;
        else if (wa_tap)
          taps[wa_idx] <= bus.wdata;
      end

      case (state)
        S_CLR: begin
          for (int j = 0; j < pTAPS; j++) x[j] <= '0;
          n_r  <= '0;
          ph_r <= '0;
        end
        S_WAIT: if (bus.ss_tvalid) begin
          x[0] <= bus.ss_tdata;
          for (int j = 1; j < pTAPS; j++) x[j] <= x[j-1];
          n_r    <= n_r + DW'(1);
          acc_r  <= '0;
          k_r    <= '0;
          emit_r <= (ph_r == '0);
          last_r <= ({1'b0, n_r} + {1'b0, decim_r}) >= {1'b0, len_r};
          ph_r   <= (ph_r == decim_r - DW'(1)) ? '0 : ph_r + DW'(1);
        end
        S_MAC: begin
          acc_r <= acc_r + prod;
          k_r   <= k_r + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_engine_dec.sv
// tb/tb_fir_engine_dec.sv - scoreboard bench for fir_engine_dec
module tb_fir_engine_dec;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  typedef struct { logic [31:0] data; logic last; } exp_t;

  logic axis_clk = 1'b0;
  logic axis_rst;
  always #5 axis_clk = ~axis_clk;

  fir_engine_dec_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_engine_dec #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAPS(NT), .pMAX_DECIM(8)) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .bus      (bus)
  );

  int          check_count = 0;
  int          error_count = 0;
  exp_t        sb[$];
  logic [31:0] tap_v [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  logic [31:0] mh [NT];
  logic [31:0] rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data);
    int t;
    @(negedge axis_clk);
    bus.awaddr = addr; bus.wdata = data; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 20) begin @(negedge axis_clk); t++; end
    if (!bus.awready) chk("aw_handshake", {31'b0, bus.awready}, 32'd1);
    @(posedge axis_clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [AW-1:0] addr, output logic [31:0] data);
    int t;
    @(negedge axis_clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge axis_clk); t++; end
    if (!bus.arready) chk("ar_handshake", {31'b0, bus.arready}, 32'd1);
    @(posedge axis_clk); #1;
    bus.arvalid = 1'b0;
    t = 0;
    while (!bus.rvalid && t < 20) begin @(negedge axis_clk); t++; end
    if (!bus.rvalid) chk("r_handshake", {31'b0, bus.rvalid}, 32'd1);
    data = bus.rdata;
    bus.rready = 1'b1;
    @(posedge axis_clk); #1;
    bus.rready = 1'b0;
  endtask

  function automatic logic [31:0] stim(input int kind, input int i);
    int t;
    t = i % 40;
    if (kind == 1) return 32'(i + 1);
    return (t < 20) ? 32'(t * 10 - 100) : 32'((40 - t) * 10 - 100);
  endfunction

  task automatic send_run(input int len, input int dec, input int kind);
    logic [31:0] xv, y;
    exp_t e;
    int t;
    for (int k = 0; k < NT; k++) mh[k] = '0;
    for (int i = 0; i < len; i++) begin
      xv = stim(kind, i);
      for (int k = NT - 1; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = xv;
      y = '0;
      for (int k = 0; k < NT; k++) y = y + tap_v[k] * mh[k];
      if (i % dec == 0) begin
        e.data = y; e.last = (i + dec >= len);
        sb.push_back(e);
      end
      @(negedge axis_clk);
      bus.ss_tdata = xv; bus.ss_tlast = (i == len - 1); bus.ss_tvalid = 1'b1;
      t = 0;
      while (!bus.ss_tready && t < 2000) begin @(negedge axis_clk); t++; end
      if (!bus.ss_tready) begin
        chk("ss_handshake", {31'b0, bus.ss_tready}, 32'd1);
        bus.ss_tvalid = 1'b0;
        return;
      end
      @(posedge axis_clk); #1;
      bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
    end
  endtask

  task automatic recv_run(input int count, input int stall_at);
    int got, cyc;
    bit stalled;
    exp_t e;
    got = 0; cyc = 0; stalled = 0;
    bus.sm_tready = 1'b1;
    while (got < count && cyc < 20000) begin
      @(negedge axis_clk); cyc++;
      if (got == stall_at && bus.sm_tvalid && !stalled) begin
        stalled = 1;
        bus.sm_tready = 1'b0;
        repeat (50) begin
          @(negedge axis_clk);
          chk("stall_valid", {31'b0, bus.sm_tvalid}, 32'd1);
          chk("stall_data", bus.sm_tdata, sb[0].data);
          chk("stall_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
        end
        bus.sm_tready = 1'b1;
      end
      if (bus.sm_tvalid && bus.sm_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {31'b0, bus.sm_tvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("out_data[%0d]", got), bus.sm_tdata, e.data);
          chk($sformatf("out_last[%0d]", got), {31'b0, bus.sm_tlast}, {31'b0, e.last});
        end
        got++;
      end
    end
    chk("out_count", 32'(got), 32'(count));
  endtask

  task automatic wait_done();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 30; i++) begin
      axil_read(12'h000, v);
      if (v[1]) break;
    end
    chk("ctrl_done_idle", v, 32'h6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit saw_valid;
    axis_rst = 1'b1;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0; bus.sm_tready = 0;
    repeat (3) @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);

    chk("rst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    chk("rst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    axil_read(12'h000, rv); chk("rst_ctrl", rv, 32'h4);
    axil_read(12'h010, rv); chk("rst_len", rv, 32'd0);
    axil_read(12'h014, rv); chk("rst_decim", rv, 32'd1);
    axil_read(12'h024, rv); chk("rst_tap1", rv, 32'd0);

    for (int k = 0; k < NT; k++) axil_write(12'(32 + 4 * k), tap_v[k]);
    axil_read(12'h024, rv); chk("tap1_rb", rv, 32'hFFFF_FFF6);
    axil_read(12'h034, rv); chk("tap5_rb", rv, 32'd63);
    axil_read(12'h04C, rv); chk("unmapped_tap11", rv, 32'd0);
    axil_read(12'h00C, rv); chk("unmapped_0c", rv, 32'd0);
    axil_write(12'h014, 32'd0); axil_read(12'h014, rv); chk("decim_zero", rv, 32'd1);
    axil_write(12'h014, 32'd9); axil_read(12'h014, rv); chk("decim_big", rv, 32'd1);
    axil_write(12'h014, 32'd8); axil_read(12'h014, rv); chk("decim_max", rv, 32'd8);

    // Run 1: 600 samples, decim 1, output stall and a busy tap write
    axil_write(12'h014, 32'd1);
    axil_write(12'h010, 32'd600);
    axil_write(12'h000, 32'd1);
    fork
      send_run(600, 1, 0);
      recv_run(600, 100);
      begin
        repeat (300) @(negedge axis_clk);
        axil_write(12'h028, 32'd77);
        axil_read(12'h028, rv);
        chk("busy_tap_write", rv, 32'hFFFF_FFF7);
        axil_read(12'h000, rv);
        chk("busy_ctrl", rv, 32'h0);
      end
    join
    wait_done();
    chk("run1_sb_empty", 32'(sb.size()), 32'd0);

    // Run 2: decim 3, ramp 1..10
    axil_write(12'h014, 32'd3);
    axil_write(12'h010, 32'd10);
    axil_write(12'h000, 32'd1);
    fork
      send_run(10, 3, 1);
      recv_run(4, -1);
    join
    wait_done();

    // Zero length run
    axil_write(12'h010, 32'd0);
    axil_write(12'h000, 32'd1);
    saw_valid = 0;
    repeat (3) begin
      @(negedge axis_clk);
      if (bus.sm_tvalid || bus.ss_tready) saw_valid = 1;
    end
    chk("len0_no_stream", {31'b0, saw_valid}, 32'd0);
    axil_read(12'h000, rv); chk("len0_done", rv, 32'h6);

    // Reset in the middle of a MAC sequence
    axil_write(12'h014, 32'd1);
    axil_write(12'h010, 32'd5);
    axil_write(12'h000, 32'd1);
    @(negedge axis_clk);
    bus.ss_tdata = 32'd7; bus.ss_tvalid = 1'b1;
    for (int t = 0; t < 20 && !bus.ss_tready; t++) @(negedge axis_clk);
    chk("rst_test_ready", {31'b0, bus.ss_tready}, 32'd1);
    @(posedge axis_clk); #1;
    bus.ss_tvalid = 1'b0;
    repeat (3) @(negedge axis_clk);
    axis_rst = 1'b1;
    #1;
    chk("midrst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    chk("midrst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    axil_read(12'h000, rv); chk("midrst_ctrl", rv, 32'h4);
    axil_read(12'h034, rv); chk("midrst_tap5", rv, 32'd0);
    axil_read(12'h010, rv); chk("midrst_len", rv, 32'd0);
    repeat (20) @(negedge axis_clk);
    chk("midrst_no_output", {31'b0, bus.sm_tvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
